div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the operand and result width in bits.
REQ-002 Port clk SHALL be input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset SHALL be input, 1 bit, asynchronous and active-high.
REQ-004 Port in_valid SHALL be input, 1 bit, indicating a request is presented.
REQ-005 Port in_ready SHALL be output, 1 bit, indicating a request can be accepted.
REQ-006 Port A SHALL be input, WIDTH bits, the dividend.
REQ-007 Port B SHALL be input, WIDTH bits, the divisor.
REQ-008 Port is_signed SHALL be input, 1 bit: 1 = two's-complement divide, 0 = unsigned divide.
REQ-009 Port out_valid SHALL be output, 1 bit, indicating results are valid.
REQ-010 Port out_ready SHALL be input, 1 bit, indicating the consumer accepts results.
REQ-011 Port quotient SHALL be output, WIDTH bits.
REQ-012 Port remainder SHALL be output, WIDTH bits.
REQ-013 Port negative SHALL be output, 1 bit, equal to quotient[WIDTH-1].
REQ-014 Port zero SHALL be output, 1 bit, high when quotient is all zeros.
REQ-015 Port div_by_zero SHALL be output, 1 bit, high when the accepted B was zero.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 in_ready SHALL be high only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high; A, B and is_signed SHALL be captured on that edge.
REQ-019 On acceptance with B nonzero, the FSM SHALL go to BUSY and load a WIDTH-cycle iteration counter.
REQ-020 On acceptance with B zero, the FSM SHALL go directly to DONE with quotient all ones, remainder = A and div_by_zero = 1.
REQ-021 In BUSY, the block SHALL perform one restoring shift-subtract step on operand magnitudes per cycle.
REQ-022 The FSM SHALL move BUSY -> DONE after exactly WIDTH steps, so out_valid rises WIDTH+1 cycles after the accepting edge (65 for WIDTH = 64).
REQ-023 In signed mode, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of A (truncating division).
REQ-024 A signed divide of the most-negative value by -1 SHALL return quotient = most-negative value and remainder = 0, with no trap.
REQ-025 out_valid SHALL be high only in DONE; quotient, remainder and flags SHALL hold stable while out_valid is high and out_ready is low.
REQ-026 DONE SHALL go to IDLE on the edge where out_ready is high; in_ready SHALL rise in the following cycle, with no same-cycle accept/complete overlap.
REQ-027 in_valid SHALL be ignored in BUSY and DONE, and operand changes after acceptance SHALL have no effect.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, negative = 0, zero = 1, div_by_zero = 0 and counter = 0.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL discard the operation without producing out_valid.

Structure
REQ-030 Shared package div_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default WIDTH constant.
REQ-031 One combinational sub-module, div_step, SHALL compute a single shift-subtract step; div_unit SHALL hold the FSM, counter, registers and sign fix-up.

Verification
REQ-032 Unsigned A = 100, B = 7 -> out_valid 65 cycles after accept; quotient = 14, remainder = 2, zero = 0, negative = 0.
REQ-033 Signed A = -7, B = 2 -> quotient = -3, remainder = -1, negative = 1.
REQ-034 B = 0, A = 0x1234 -> out_valid 1 cycle after accept; quotient = all ones, remainder = 0x1234, div_by_zero = 1.
REQ-035 Signed A = 0x8000_0000_0000_0000, B = -1 -> quotient = 0x8000_0000_0000_0000, remainder = 0.
REQ-036 Hold out_ready = 0 for 10 cycles in DONE -> outputs stable, in_ready = 0; a new in_valid during BUSY is not accepted.
REQ-037 Assert reset at cycle 30 of BUSY -> in_ready = 1 and out_valid = 0 immediately; the next request completes correctly.
REQ-038 Random regression of 5000 signed and unsigned operand pairs -> results match the reference / and % operators with truncating semantics.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the iterative divider.
//   DIV_WIDTH : default operand/result width
//   state_e   : divider control states (IDLE, BUSY, DONE)
package div_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-subtract step on unsigned magnitudes.
//   rem_i     : partial remainder entering the step (always < divisor_i)
//   quo_i     : dividend bits still to consume (MSB first); quotient bits
//               are shifted in at the LSB end as dividend bits leave
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after the step
//   quo_o     : shifted dividend/quotient register after the step
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        // Since rem_i < divisor, shifted < 2*divisor, so a non-negative
        // difference always fits in WIDTH bits and diff[WIDTH] is a clean borrow.
        quo_o   = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
        rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider, signed or unsigned, one quotient
// bit per cycle.
//   clk, reset              : clock, asynchronous active-high reset
//   in_valid / in_ready     : request handshake (A, B, is_signed)
//   out_valid / out_ready   : result handshake
//   quotient, remainder     : results (truncating division in signed mode)
//   negative, zero          : quotient MSB / quotient all zeros
//   div_by_zero             : the accepted divisor was zero
//   dbg_state               : current control state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; results
// are held while out_valid is high and out_ready is low.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             negative,
    output logic             zero,
    output logic             div_by_zero,
    output state_e           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] quotient_d;
    logic [WIDTH-1:0] remainder_d;

    // Magnitudes of the presented operands. The most-negative value maps to
    // itself, which is its correct unsigned magnitude.
    always_comb begin
        a_neg = is_signed & A[WIDTH-1];
        b_neg = is_signed & B[WIDTH-1];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Sign fix-up applied to the output of the final step. MIN / -1 wraps
    // back to MIN with remainder 0, so no overflow trap is needed.
    always_comb begin
        quotient_d  = q_neg_q ? -step_quo : step_quo;
        remainder_d = r_neg_q ? -step_rem : step_rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (B == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= A;
                            dbz_q       <= 1'b1;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dvs_q   <= b_mag;
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            dbz_q   <= 1'b0;
                            cnt_q   <= CNT_W'(WIDTH);
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Last step retires straight into the result registers.
                    if (cnt_q == CNT_W'(1)) begin
                        quotient_q  <= quotient_d;
                        remainder_q <= remainder_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign negative    = quotient_q[WIDTH-1];
    assign zero        = (quotient_q == '0);
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule
